// File: rtl/elapsed_time_bcd.sv
// rtl/elapsed_time_bcd.sv - elapsed game time counter, 000..999 seconds in packed BCD
module elapsed_time_bcd #(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter logic [11:0] MAX_BCD  = 12'h999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic       running,
   output logic       sec_tick,
   output logic       sat,
   output logic [3:0] a0,
   output logic [3:0] a1,
   output logic [3:0] a2
);

   localparam int unsigned   PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      SAT   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [11:0]    digits_q, digits_d;
   logic           sec_tick_q, sec_tick_d;
   logic           running_q, running_d;
   logic           sat_q, sat_d;
   logic [11:0]    digits_inc;
   logic           wrap;

   // Ripple-carry BCD increment; no nibble ever leaves 0..9.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         if (v[7:4] == 4'd9) begin
            r[7:4] = 4'd0;
            if (v[11:8] == 4'd9) begin
               r[11:8] = 4'd0;
            end else begin
               r[11:8] = v[11:8] + 4'd1;
            end
         end else begin
            r[7:4] = v[7:4] + 4'd1;
         end
      end else begin
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   assign digits_inc = bcd_inc(digits_q);
   assign wrap       = (state_q == RUN) && (presc_q == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         digits_q   <= '0;
         sec_tick_q <= 1'b0;
         running_q  <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         digits_q   <= digits_d;
         sec_tick_q <= sec_tick_d;
         running_q  <= running_d;
         sat_q      <= sat_d;
      end
   end

   // Command priority is clear > pause > start in every state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!clear && !pause && start) state_d = RUN;
         end
         RUN: begin
            if (clear) begin
               state_d = IDLE;
            end else if (pause) begin
               state_d = PAUSE;
            end else if (wrap && (digits_inc == MAX_BCD)) begin
               state_d = SAT;
            end
         end
         PAUSE: begin
            if (clear) begin
               state_d = IDLE;
            end else if (!pause && start) begin
               state_d = RUN;
            end
         end
         SAT: begin
            if (clear) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Prescaler and digits advance only in RUN when no pause or clear competes for the cycle.
   always_comb begin
      presc_d    = presc_q;
      digits_d   = digits_q;
      sec_tick_d = 1'b0;
      if (clear) begin
         presc_d  = '0;
         digits_d = '0;
      end else if ((state_q == RUN) && !pause) begin
         if (wrap) begin
            presc_d    = '0;
            digits_d   = digits_inc;
            sec_tick_d = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_comb begin
      running_d = (state_d == RUN);
      sat_d     = (state_d == SAT);
   end

   assign running  = running_q;
   assign sat      = sat_q;
   assign sec_tick = sec_tick_q;
   assign a0       = digits_q[3:0];
   assign a1       = digits_q[7:4];
   assign a2       = digits_q[11:8];

endmodule

// File: tb/tb_elapsed_time_bcd.sv
// tb/tb_elapsed_time_bcd.sv - directed bench with tick scoreboard for elapsed_time_bcd
module tb_elapsed_time_bcd;

   localparam int TDIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, pause, clear;
   logic       running, sec_tick, sat;
   logic [3:0] a0, a1, a2;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_val = 0;
   int sb_q[$];

   elapsed_time_bcd #(.TICK_DIV(TDIV), .MAX_BCD(12'h999)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
      .running(running), .sec_tick(sec_tick), .sat(sat),
      .a0(a0), .a1(a1), .a2(a2)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_bcd(input int v);
      return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   function automatic int digits();
      return int'({a2, a1, a0});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         exp_val++;
         sb_q.push_back(to_bcd(exp_val));
         repeat (TDIV) cyc();
      end
   endtask

   // Every observed tick must match the next pushed expectation.
   always @(negedge clk) begin
      int e;
      if (rst_n && sec_tick) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_tick", int'(sec_tick), 0);
         end else begin
            e = sb_q.pop_front();
            chk("tick_digits", digits(), e);
            chk("nibble_range", int'((a2 > 4'd9) || (a1 > 4'd9) || (a0 > 4'd9)), 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
      repeat (2) cyc();
      chk("rst_digits", digits(), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_tick", int'(sec_tick), 0);
      chk("rst_sat", int'(sat), 0);
      rst_n = 1'b1;
      cyc();

      // 1: ticks at 4, 8, 12 cycles after the RUN entry edge
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("t1_running", int'(running), 1);
      for (int i = 1; i <= 3; i++) begin
         exp_val++;
         sb_q.push_back(to_bcd(exp_val));
      end
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk($sformatf("t1_tick_c%0d", k), int'(sec_tick), int'(k % TDIV == 0));
      end
      chk("t1_digits", digits(), 'h003);
      chk("t1_running2", int'(running), 1);

      // 2: carries 009->010 and 099->100
      run_ticks(6);
      chk("t2_009", digits(), 'h009);
      run_ticks(1);
      chk("t2_010", digits(), 'h010);
      run_ticks(89);
      chk("t2_099", digits(), 'h099);
      run_ticks(1);
      chk("t2_100", digits(), 'h100);

      // 3: pause at prescaler 2, held with start also high, then resume
      repeat (2) cyc();
      pause = 1'b1;
      cyc();
      chk("t3_paused", int'(running), 0);
      start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("t3_frozen_tick", int'(sec_tick), 0);
      end
      chk("t3_frozen_digits", digits(), 'h100);
      chk("t3_pause_blocks_start", int'(running), 0);
      pause = 1'b0;
      cyc();
      start = 1'b0;
      chk("t3_resumed", int'(running), 1);
      cyc();
      chk("t3_no_early_tick", int'(sec_tick), 0);
      exp_val++;
      sb_q.push_back(to_bcd(exp_val));
      cyc();
      chk("t3_tick_2_after", int'(sec_tick), 1);

      // 5: pause on the tick cycle, then clear on the tick cycle
      repeat (3) cyc();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      chk("t5_pause_no_tick", int'(sec_tick), 0);
      chk("t5_pause_digits", digits(), 'h101);
      start = 1'b1;
      cyc();
      start = 1'b0;
      exp_val++;
      sb_q.push_back(to_bcd(exp_val));
      cyc();
      chk("t5_resume_tick", int'(sec_tick), 1);
      repeat (3) cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      exp_val = 0;
      chk("t5_clear_digits", digits(), 0);
      chk("t5_clear_tick", int'(sec_tick), 0);
      chk("t5_clear_idle", int'(running), 0);
      repeat (6) cyc();
      chk("t5_idle_holds", digits(), 0);

      // 6: asynchronous reset mid-RUN at 057
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_ticks(57);
      chk("t6_057", digits(), 'h057);
      repeat (2) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_digits", digits(), 0);
      chk("t6_async_running", int'(running), 0);
      exp_val = 0;
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (8) cyc();
      chk("t6_stay_idle", int'(running), 0);
      chk("t6_stay_zero", digits(), 0);

      // 4: saturation at 999
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_ticks(998);
      chk("t4_998", digits(), 'h998);
      chk("t4_998_sat", int'(sat), 0);
      run_ticks(1);
      chk("t4_999", digits(), 'h999);
      chk("t4_sat", int'(sat), 1);
      chk("t4_not_running", int'(running), 0);
      start = 1'b1;
      repeat (6) cyc();
      pause = 1'b1;
      repeat (6) cyc();
      start = 1'b0;
      pause = 1'b0;
      repeat (8) cyc();
      chk("t4_hold_999", digits(), 'h999);
      chk("t4_hold_sat", int'(sat), 1);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("t4_clear_digits", digits(), 0);
      chk("t4_clear_sat", int'(sat), 0);
      chk("t4_clear_running", int'(running), 0);

      cyc();
      chk("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
